// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the 2:1 round-robin mux arbiter.
// Source indices double as the mux select and the round-robin "last" value.
package mux2_arb_pkg;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // Output-register occupancy; out_valid is simply (state == FULL).
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/mux2_rr_pick.sv
// Combinational round-robin pick between two requesters.
// i_last is the index of the most recently granted source; on contention
// the other source wins.
module mux2_rr_pick
  import mux2_arb_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last,
  output logic o_gnt0,
  output logic o_gnt1
);

  // A lone requester always wins; on contention the source not served last wins.
  always_comb begin
    o_gnt0 = i_valid0 & (~i_valid1 | (i_last == SRC1));
    o_gnt1 = i_valid1 & (~i_valid0 | (i_last == SRC0));
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Upstream control stage for the 2:1 select mux.
// Arbitrates two valid/ready sources round-robin and holds the chosen word in
// a one-entry output register together with its registered mux select s.
// Optional feature: define MUX2_ARB_CNT_EN to add saturating grant counters
// cnt0/cnt1; without it those ports and counters are absent.
//
// Handshake: a word moves on a rising edge when valid and ready are both high
// on that edge. iN_ready = gntN & space, where space = !out_valid | out_ready,
// so the output register can drain and refill on the same edge with no bubble.
// Readys are combinational from valids, last and out state; during reset they
// still follow the grant logic, so sources must ignore handshakes while
// rst_n is low.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             s
`ifdef MUX2_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  out_state_t       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_s;
  logic             r_last;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_space;
  logic             w_acc0;
  logic             w_acc1;
  logic [WIDTH-1:0] w_mux_data;

  mux2_rr_pick u_pick (
    .i_valid0 (i0_valid),
    .i_valid1 (i1_valid),
    .i_last   (r_last),
    .o_gnt0   (w_gnt0),
    .o_gnt1   (w_gnt1)
  );

  // Space, readys, accepts and the input-side 2:1 data mux steered by the grant.
  always_comb begin
    w_space    = (r_state == EMPTY) | out_ready;
    i0_ready   = w_gnt0 & w_space;
    i1_ready   = w_gnt1 & w_space;
    w_acc0     = i0_valid & i0_ready;
    w_acc1     = i1_valid & i1_ready;
    w_mux_data = w_gnt1 ? i1_data : i0_data;
  end

  // Output-register FSM: load on accept (replacing any word drained this edge),
  // otherwise empty on drain; data and select hold when not loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_s     <= SRC0;
      r_last  <= SRC1;
    end else if (w_acc0 | w_acc1) begin
      r_state <= FULL;
      r_data  <= w_mux_data;
      r_s     <= w_acc1 ? SRC1 : SRC0;
      r_last  <= w_acc1 ? SRC1 : SRC0;
    end else if (out_ready) begin
      r_state <= EMPTY;
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign s         = r_s;

`ifdef MUX2_ARB_CNT_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Per-source accept counters that stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_acc0 && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_acc1 && (r_cnt1 != {CNT_W{1'b1}})) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign cnt0 = r_cnt0;
  assign cnt1 = r_cnt1;
`else
  // Counter width only matters when the counters are built.
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
